serial_subbit_sub: RTL and testbench
====================================

// Module: serial_subbit_sub
// PURPOSE
//  Bit-serial two's-complement subtractor: diff = a - b, computed LSB-first, one bit per clock.
//  It is the inverse-operation companion to the combinational full-adder cell. It serves
//  area-constrained datapaths that trade latency for a single 1-bit difference cell
//  plus shift registers. A start/busy/done handshake frames each operation.
// PARAMETERS
//  WIDTH  8  operand and result width in bits (>= 2)
// PORTS
//  clk    in   1      rising-edge clock, single clock domain
//  rst_n  in   1      asynchronous active-low reset
//  start  in   1      request; sampled only in IDLE
//  a      in   WIDTH  minuend; captured on the accepted start edge
//  b      in   WIDTH  subtrahend; captured on the accepted start edge
//  busy   out  1      high in SHIFT state
//  done   out  1      one-cycle pulse; result valid from this cycle on
//  diff   out  WIDTH  a - b mod 2^WIDTH; held until next accepted start
//  bout   out  1      final borrow; 1 iff unsigned a < b
//  ovf    out  1      signed overflow: a[MSB]!=b[MSB] && diff[MSB]!=a[MSB]
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE. busy, done, diff, bout, ovf, the borrow register,
//    the bit counter and the operand shift registers all clear to 0. This applies
//    mid-operation too; the in-flight operation is abandoned with no done pulse.
//  - FSM is IDLE -> SHIFT -> DONE -> IDLE. All outputs are registered.
//    IDLE: start=1 at edge E0 loads the a/b shift registers, sets borrow=0 and cnt=WIDTH-1,
//      moves to SHIFT, and clears done. diff/bout/ovf keep their old values until E0.
//      From E0 they read as undefined-in-progress; the TB checks them only at done.
//    SHIFT: each edge computes d = a0^b0^br and br' = (~a0&b0)|(~(a0^b0)&br).
//      It right-shifts a/b and shifts d into diff[WIDTH-1]; diff is the result register.
//      At cnt==0 it moves to DONE; otherwise cnt decrements.
//    DONE: busy=0, done=1 for exactly one cycle. bout=br and ovf are computed from the
//      captured MSBs. Next edge goes to IDLE unconditionally.
//  - Latency: start accepted at E0 gives done=1 in the cycle after edge E0+WIDTH.
//    Throughput is one operation per WIDTH+2 cycles.
//  - start while busy or in DONE: ignored, with no queuing and no effect on the result.
//  - a/b may change freely after E0; only the values captured at E0 are used.
//  - Arithmetic is modulo 2^WIDTH. bout and ovf are independent flags and may both be 1.
//  - The counter is $clog2(WIDTH) bits and never wraps: it stops at 0 on leaving SHIFT.
// STRUCTURE
//  - Shared package/include arith_defs: state encoding localparams S_IDLE=2'd0,
//    S_SHIFT=2'd1, S_DONE=2'd2 (2'd3 is illegal and recovers to IDLE).
//  - Sub-module subbit: combinational 1-bit full subtractor with ports (bin, a, b, d, bout).
//    It is instantiated once, and the top holds the FSM, counter and shift registers.
// TESTING (WIDTH=8)
//  1. a=0x35, b=0x12, start 1 cycle -> busy for 8 cycles, done at E0+8:
//     diff=0x23, bout=0, ovf=0.
//  2. a=0x00, b=0x01 -> diff=0xFF, bout=1, ovf=0.
//  3. a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1.
//     a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
//  4. Start a=0x10, b=0x03, then pulse start with a=0xAA, b=0x55 at E0+3 and in the DONE
//     cycle -> single done, diff=0x0D. No second operation starts.
//  5. rst_n=0 asynchronously at E0+4 -> busy/done/diff/bout/ovf=0 before the next edge and no
//     done. After release, a=0x05, b=0x05 -> diff=0x00, bout=0, ovf=0.
//  6. Random sweep of 1000 ops against a-b reference model.
//     Hold start=1 continuously -> one done every 10 cycles.

Source files
------------

// File: rtl/serial_subbit_sub_pkg.sv
// serial_subbit_sub_pkg: FSM state encoding shared by the serial subtractor
package serial_subbit_sub_pkg;
  // 2'd3 is unused and falls back to S_IDLE
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/serial_subbit_sub_subbit.sv
// subbit: combinational 1-bit full subtractor (d = a - b - bin)
//  bin  in  borrow in
//  a    in  minuend bit
//  b    in  subtrahend bit
//  d    out difference bit
//  bout out borrow out
module subbit (
  input  logic bin,
  input  logic a,
  input  logic b,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subbit_sub.sv
// serial_subbit_sub: bit-serial a-b, LSB first, one bit per clock, start/busy/done framed
//  clk, rst_n       clock, async active-low reset
//  start, a, b      request and operands, captured when accepted in IDLE
//  busy, done       busy while shifting, one-cycle done pulse when result is valid
//  diff, bout, ovf  a-b mod 2^WIDTH, unsigned borrow, signed overflow
module serial_subbit_sub
  import serial_subbit_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_amsb, r_bmsb;
  logic             w_d, w_bo;
  subbit u_cell (.bin(r_br), .a(r_a[0]), .b(r_b[0]), .d(w_d), .bout(w_bo));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_amsb  <= 1'b0;
      r_bmsb  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_amsb  <= a[WIDTH-1];
            r_bmsb  <= b[WIDTH-1];
            r_br    <= 1'b0;
            r_cnt   <= CW'(WIDTH - 1);
            busy    <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_a  <= r_a >> 1;
          r_b  <= r_b >> 1;
          r_br <= w_bo;
          diff <= {w_d, diff[WIDTH-1:1]};
          if (r_cnt == '0) begin
            // last bit: w_d is the result MSB, so the flags can be registered now
            busy    <= 1'b0;
            done    <= 1'b1;
            bout    <= w_bo;
            ovf     <= (r_amsb != r_bmsb) && (w_d != r_amsb);
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subbit_sub.sv
// tb_serial_subbit_sub: randomized self-checking bench against an arithmetic reference model
module tb_serial_subbit_sub;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done, bout, ovf;
  logic [7:0] diff;
  int         n_vec = 0;
  int         n_err = 0;
  always #5 clk = ~clk;
  serial_subbit_sub #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void ref_sub(input logic [7:0] x, input logic [7:0] y,
                                  output logic [7:0] d, output logic bo, output logic ov);
    int sd;
    d  = 8'(x - y);
    bo = x < y;
    sd = int'($signed(x)) - int'($signed(y));
    ov = (sd < -128) || (sd > 127);
  endfunction
  task automatic check_result(input string tag, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] ed;
    logic       eb, eo;
    ref_sub(x, y, ed, eb, eo);
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_bout"}, 32'(bout), 32'(eb));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
  endtask
  // called #1 after a posedge with the DUT idle; returns #1 after the edge leaving DONE
  task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y);
    int k;
    start = 1'b1;
    a = x;
    b = y;
    @(posedge clk);
    #1 start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    k = 0;
    while (k < 20 && !done) begin
      @(posedge clk);
      #1 k++;
      if (k == 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
    chk({tag, "_lat"}, 32'(k), 32'd8);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check_result(tag, x, y);
    @(posedge clk);
    #1 chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask
  initial begin
    int dcount;
    int last;
    start = 1'b0;
    a = '0;
    b = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_flags", 32'({bout, ovf}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("t1", 8'h35, 8'h12);
    chk("t1_diff_const", 32'(diff), 32'h23);
    run_op("t2", 8'h00, 8'h01);
    chk("t2_diff_const", 32'(diff), 32'hFF);
    run_op("t3a", 8'h80, 8'h01);
    chk("t3a_ovf_const", 32'(ovf), 32'd1);
    run_op("t3b", 8'h7F, 8'hFF);
    chk("t3b_flags_const", 32'({bout, ovf}), 32'h3);
    // start pulses during SHIFT and in the DONE cycle must be ignored
    start = 1'b1;
    a = 8'h10;
    b = 8'h03;
    @(posedge clk);
    #1 start = 1'b0;
    dcount = 0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      #1;
      if (c >= 10) chk("t4_idle", 32'(busy), 32'd0);
      if (done) begin
        dcount++;
        chk("t4_diff", 32'(diff), 32'h0D);
        chk("t4_flags", 32'({bout, ovf}), 32'd0);
      end
      start = (c == 3) || done;
      a = 8'hAA;
      b = 8'h55;
    end
    start = 1'b0;
    chk("t4_one_done", 32'(dcount), 32'd1);
    // asynchronous reset mid-operation
    start = 1'b1;
    a = 8'h77;
    b = 8'h11;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_diff", 32'(diff), 32'd0);
    chk("t5_flags", 32'({bout, ovf}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    dcount = 0;
    repeat (12) begin
      @(posedge clk);
      #1 if (done) dcount++;
    end
    chk("t5_no_done", 32'(dcount), 32'd0);
    run_op("t5", 8'h05, 8'h05);
    // random sweep
    for (int i = 0; i < 1000; i++) run_op("rnd", 8'($urandom), 8'($urandom));
    // start held high: one done every WIDTH+2 cycles
    start = 1'b1;
    a = 8'($urandom);
    b = 8'($urandom);
    dcount = 0;
    last = -1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        chk("hold_gap", 32'(c), 32'(last < 0 ? 9 : last + 10));
        check_result("hold", a, b);
        last = c;
        dcount++;
      end
    end
    start = 1'b0;
    chk("hold_count", 32'(dcount), 32'd5);
    repeat (12) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
